// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller: FSM state type and default
// parameter values.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_ADDR_BASE   = 1024;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 4;
  localparam int unsigned DEFAULT_SRAM_AW     = 18;

endpackage

// File: rtl/sram_controller_wait_counter.sv
// Wait-cycle counter for one SRAM half access.
// Counts 0..WAIT_CYCLES-1 while enabled and wraps to 0 after the terminal count.
// Ports:
//   clk    in  clock
//   rst    in  synchronous active-high reset
//   clear  in  force count to 0
//   enable in  advance count
//   tc     out count == WAIT_CYCLES-1
module sram_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(WAIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Data-memory controller between the MEM stage and a 16-bit asynchronous SRAM.
// Each 32-bit word is transferred as two halves (low then high), each held on
// the bus for WAIT_CYCLES clocks. ready drops while an access is in flight.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   wr_en, rd_en   store / load request, held until ready
//   addr, wdata    byte address and store data
//   rdata, ready   load data, 0 = freeze pipeline
//   sram_addr      half-word address to SRAM
//   sram_we_n      write strobe, active low
//   sram_dq_out    data to SRAM, sram_dq_oe = controller drives DQ
//   sram_dq_in     data from SRAM
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned ADDR_BASE   = DEFAULT_ADDR_BASE,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int unsigned SRAM_AW     = DEFAULT_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in
);

  state_t             state, state_next;
  logic [SRAM_AW-2:0] waddr_q;
  logic [31:0]        wdata_q;
  logic               write_q;
  logic               req;
  logic               tc;
  logic               cnt_clear;
  logic               cnt_en;
  logic [31:0]        offset;
  logic               unused_offset;

  assign req    = rd_en | wr_en;
  assign offset = addr - ADDR_BASE;
  // Byte lane bits and bits beyond the SRAM's reach are dropped by the map.
  assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .enable(cnt_en),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rdata   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && req) begin
        waddr_q <= offset[SRAM_AW:2];
        wdata_q <= wdata;
        write_q <= wr_en;
      end
      if (!write_q && tc) begin
        if (state == ST_LOW)  rdata[15:0]  <= sram_dq_in;
        if (state == ST_HIGH) rdata[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    state_next  = state;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_we_n   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        ready     = !req;
        if (req) state_next = ST_LOW;
      end
      ST_LOW: begin
        cnt_en      = 1'b1;
        sram_addr   = {waddr_q, 1'b0};
        sram_dq_out = wdata_q[15:0];
        if (write_q) begin
          sram_dq_oe = 1'b1;
          // Strobe released on the last cycle so address/data are held past it.
          sram_we_n  = tc;
        end
        if (tc) state_next = ST_HIGH;
      end
      ST_HIGH: begin
        cnt_en      = 1'b1;
        sram_addr   = {waddr_q, 1'b1};
        sram_dq_out = wdata_q[31:16];
        if (write_q) begin
          sram_dq_oe = 1'b1;
          sram_we_n  = tc;
        end
        if (tc) state_next = ST_DONE;
      end
      ST_DONE: begin
        ready      = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
